// File: rtl/uart_tx_cfg.sv
// UART transmitter: runtime frame format (5..DBIT_MAX data bits, parity mode, 1/1.5/2 stop bits),
// valid/ready word input with per-frame config latching, and line-break generation.
module uart_tx_cfg #(
  parameter int DBIT_MAX   = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_baud_tick,
  input  logic [DBIT_MAX-1:0] i_data,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [2:0]          i_data_num,
  input  logic [2:0]          i_par,
  input  logic [1:0]          i_stop_num,
  input  logic                i_break,
  output logic                o_tx,
  output logic                o_busy,
  output logic                o_tx_done_tick
);

  localparam int TW = $clog2(2 * OVERSAMPLE);
  localparam int BW = $clog2(DBIT_MAX + 1);

  localparam logic [3:0]    DMAX4   = 4'(DBIT_MAX);
  localparam logic [TW-1:0] LIM_1   = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] LIM_1P5 = TW'(3 * OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LIM_2   = TW'(2 * OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK, S_GUARD
  } state_e;

  typedef enum logic [2:0] {
    PAR_NONE, PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE
  } par_e;

  typedef enum logic [1:0] {
    STOP_1, STOP_1P5, STOP_2
  } stop_e;

  function automatic logic par_bit(input par_e mode, input logic acc);
    case (mode)
      PAR_EVEN: par_bit = acc;
      PAR_ODD:  par_bit = ~acc;
      PAR_MARK: par_bit = 1'b1;
      default:  par_bit = 1'b0;
    endcase
  endfunction

  state_e              state_q, state_d;
  logic [TW-1:0]       tick_q, tick_d, tick_lim;
  logic [BW-1:0]       bit_q, bit_d, nbits_q, nbits_d, nbits_in;
  logic [DBIT_MAX-1:0] shreg_q, shreg_d;
  logic                acc_q, acc_d;
  par_e                par_q, par_d, par_in;
  stop_e               stop_q, stop_d, stop_in;
  logic                tx_q, tx_d;
  logic                done_q, done_d;
  logic [3:0]          nbits_req;
  logic                accept, bit_end, last_bit;

  // Config decode for the word presented at the input; only captured on accept.
  assign nbits_req = 4'd5 + {1'b0, i_data_num};
  assign nbits_in  = (nbits_req > DMAX4) ? BW'(DMAX4) : BW'(nbits_req);

  always_comb begin
    par_in  = PAR_NONE;
    stop_in = STOP_2;
    case (i_par)
      3'b001:  par_in = PAR_EVEN;
      3'b010:  par_in = PAR_ODD;
      3'b011:  par_in = PAR_MARK;
      3'b100:  par_in = PAR_SPACE;
      default: par_in = PAR_NONE;
    endcase
    case (i_stop_num)
      2'b00:   stop_in = STOP_1;
      2'b01:   stop_in = STOP_1P5;
      default: stop_in = STOP_2;
    endcase
  end

  // Only the stop bit has a non-default length; everything else is one bit period.
  always_comb begin
    tick_lim = LIM_1;
    if (state_q == S_STOP) begin
      case (stop_q)
        STOP_1:   tick_lim = LIM_1;
        STOP_1P5: tick_lim = LIM_1P5;
        default:  tick_lim = LIM_2;
      endcase
    end
  end

  assign o_ready  = (state_q == S_IDLE) & ~i_break;
  assign accept   = i_valid & o_ready;
  assign bit_end  = i_baud_tick && (tick_q == tick_lim);
  assign last_bit = (bit_q == nbits_q - BW'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      nbits_q <= '0;
      shreg_q <= '0;
      acc_q   <= 1'b0;
      par_q   <= PAR_NONE;
      stop_q  <= STOP_1;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      nbits_q <= nbits_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  // Break wins over a pending word in IDLE; elsewhere i_break is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_break)      state_d = S_BREAK;
        else if (i_valid) state_d = S_START;
      end
      S_START:  if (bit_end) state_d = S_DATA;
      S_DATA: begin
        if (bit_end && last_bit) state_d = (par_q == PAR_NONE) ? S_STOP : S_PARITY;
      end
      S_PARITY: if (bit_end) state_d = S_STOP;
      S_STOP:   if (bit_end) state_d = S_IDLE;
      S_BREAK:  if (!i_break) state_d = S_GUARD;
      S_GUARD:  if (bit_end) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: every signal assigned in this block gets a default up front so no
  // path through the case leaves it unassigned, which would infer a latch.
  always_comb begin
    tick_d  = tick_q;
    bit_d   = bit_q;
    nbits_d = nbits_q;
    shreg_d = shreg_q;
    acc_d   = acc_q;
    par_d   = par_q;
    stop_d  = stop_q;

    case (state_q)
      S_IDLE: begin
        tick_d = '0;
        if (accept) begin
          shreg_d = i_data;
          nbits_d = nbits_in;
          par_d   = par_in;
          stop_d  = stop_in;
          bit_d   = '0;
          acc_d   = 1'b0;
        end
      end
      S_BREAK: tick_d = '0;
      default: begin
        if (i_baud_tick) tick_d = bit_end ? '0 : tick_q + TW'(1);
      end
    endcase

    if (state_q == S_DATA && bit_end) begin
      acc_d   = acc_q ^ shreg_q[0];
      shreg_d = shreg_q >> 1;
      bit_d   = bit_q + BW'(1);
    end

    // The line is driven from the next state so it moves on the same edge as the FSM.
    case (state_d)
      S_START, S_BREAK: tx_d = 1'b0;
      S_DATA:           tx_d = shreg_d[0];
      S_PARITY:         tx_d = par_bit(par_d, acc_d);
      default:          tx_d = 1'b1;
    endcase

    done_d = (state_q == S_STOP) && bit_end;
  end

  assign o_tx           = tx_q;
  assign o_tx_done_tick = done_q;
  assign o_busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: a line monitor decodes frames/breaks on o_tx
// and compares them against expectations queued by the stimulus.
module tb_uart_tx_cfg;

  localparam int OS   = 16;
  localparam int DMAX = 9;

  typedef struct {
    bit         is_break;
    int         brk_clks;
    bit         b2b;
    bit         chk_bitclk;
    logic [8:0] data;
    int         nbits;
    bit         par_en;
    bit         par_val;
    int         total_ticks;
  } exp_t;

  typedef enum {M_IDLE, M_FRAME, M_BRK, M_GUARD} mon_e;

  logic       i_clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_baud_tick = 1'b0;
  logic [8:0] i_data = '0;
  logic       i_valid = 1'b0;
  logic       i_valid8 = 1'b0;
  logic [2:0] i_data_num = '0;
  logic [2:0] i_par = '0;
  logic [1:0] i_stop_num = '0;
  logic       i_break = 1'b0;
  logic       o_ready, o_tx, o_busy, o_tx_done_tick;
  logic       o_ready8, o_tx8, o_busy8, o_tx_done_tick8;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t cur;
  mon_e mstate = M_IDLE;
  bit   mon_busy = 1'b0;
  int   done_cnt = 0;
  int   exp_done = 0;
  int   cyc = 0;

  uart_tx_cfg #(.DBIT_MAX(DMAX), .OVERSAMPLE(OS)) u_dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_baud_tick(i_baud_tick),
    .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .i_data_num(i_data_num), .i_par(i_par), .i_stop_num(i_stop_num),
    .i_break(i_break), .o_tx(o_tx), .o_busy(o_busy), .o_tx_done_tick(o_tx_done_tick)
  );

  uart_tx_cfg #(.DBIT_MAX(8), .OVERSAMPLE(OS)) u_dut8 (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_baud_tick(i_baud_tick),
    .i_data(i_data[7:0]), .i_valid(i_valid8), .o_ready(o_ready8),
    .i_data_num(i_data_num), .i_par(i_par), .i_stop_num(i_stop_num),
    .i_break(1'b0), .o_tx(o_tx8), .o_busy(o_busy8), .o_tx_done_tick(o_tx_done_tick8)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model of one frame built straight from the frame-format rules.
  function automatic exp_t mk_frame(input logic [8:0] d, input int num, input int par,
                                    input int stop, input int dmax);
    exp_t e;
    int   nb, st;
    logic [8:0] mask;
    logic x;
    e = '{default: 0};
    nb = 5 + num;
    if (nb > dmax) nb = dmax;
    mask = '0;
    for (int i = 0; i < nb; i++) mask[i] = 1'b1;
    e.data  = d & mask;
    e.nbits = nb;
    x = ^e.data;
    case (par)
      1:       begin e.par_en = 1; e.par_val = x;    end
      2:       begin e.par_en = 1; e.par_val = ~x;   end
      3:       begin e.par_en = 1; e.par_val = 1'b1; end
      4:       begin e.par_en = 1; e.par_val = 1'b0; end
      default: e.par_en = 0;
    endcase
    case (stop)
      0:       st = OS;
      1:       st = OS * 3 / 2;
      default: st = 2 * OS;
    endcase
    e.total_ticks = OS * (1 + nb + (e.par_en ? 1 : 0)) + st;
    return e;
  endfunction

  initial begin : tick_gen
    int div;
    div = 0;
    forever begin
      @(negedge i_clk);
      div = (div == 3) ? 0 : div + 1;
      i_baud_tick = (div == 3);
    end
  end

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation did not finish, got %0d vectors expected completion", n_vec);
    $fatal(1, "watchdog expired");
  end

  // Line monitor: samples one time unit after each rising edge.
  initial begin : monitor
    bit          prev_tx;
    int          c, nsamp, ntr, tr0, tr1, lowc, last_done;
    bit          bad_edge, guard_ok, stop_ok;
    logic [31:0] line;
    logic [8:0]  got;
    int          pidx;
    prev_tx = 1'b1; c = 0; nsamp = 0; ntr = 0; tr0 = 0; tr1 = 0; lowc = 0;
    last_done = -100; bad_edge = 0; guard_ok = 1; line = '0;
    forever begin
      @(posedge i_clk); #1;
      cyc++;
      if (o_tx_done_tick) done_cnt++;
      if (!i_reset_n) begin
        mstate = M_IDLE; mon_busy = 1'b0; prev_tx = 1'b1;
      end else begin
        case (mstate)
          M_IDLE: begin
            if (prev_tx && !o_tx) begin
              if (sb.size() == 0) begin
                check("unexpected_start", 32'(o_tx), 32'd1);
              end else begin
                cur = sb.pop_front();
                mon_busy = 1'b1; c = 0; line = '0; nsamp = 0; bad_edge = 0; ntr = 0; lowc = 1;
                if (cur.b2b) check("b2b_gap", 32'(cyc - last_done), 32'd1);
                mstate = cur.is_break ? M_BRK : M_FRAME;
              end
            end
          end
          M_FRAME: begin
            if (i_baud_tick) begin
              c++;
              if (c >= OS / 2 && ((c - OS / 2) % OS) == 0 && nsamp < 32) begin
                line[nsamp] = o_tx;
                nsamp++;
              end
            end
            if (o_tx != prev_tx) begin
              if ((c % OS) != 0) bad_edge = 1'b1;
              if (ntr == 0) tr0 = cyc;
              else if (ntr == 1) tr1 = cyc;
              ntr++;
            end
            if (o_tx_done_tick) begin
              got = '0;
              for (int i = 0; i < cur.nbits; i++) got[i] = line[1 + i];
              pidx = 1 + cur.nbits;
              stop_ok = 1'b1;
              for (int k = pidx + (cur.par_en ? 1 : 0); k < nsamp; k++)
                if (line[k] !== 1'b1) stop_ok = 1'b0;
              check("start_bit", 32'(line[0]), 32'd0);
              check("data_bits", 32'(got), 32'(cur.data));
              if (cur.par_en) check("parity_bit", 32'(line[pidx]), 32'(cur.par_val));
              check("stop_high", 32'(stop_ok), 32'd1);
              check("frame_ticks", 32'(c), 32'(cur.total_ticks));
              check("bit_edges_on_boundary", 32'(bad_edge), 32'd0);
              if (cur.chk_bitclk) check("bit_clocks", 32'(tr1 - tr0), 32'(OS * 4));
              last_done = cyc;
              mstate = M_IDLE; mon_busy = 1'b0;
            end else if (c > cur.total_ticks + OS) begin
              check("frame_timeout", 32'(c), 32'(cur.total_ticks));
              mstate = M_IDLE; mon_busy = 1'b0;
            end
          end
          M_BRK: begin
            if (o_tx) begin
              if (cur.brk_clks > 0) check("break_low_clks", 32'(lowc), 32'(cur.brk_clks));
              mstate = M_GUARD; c = 0; guard_ok = 1'b1;
            end else begin
              lowc++;
              if (lowc > 20000) begin
                check("break_timeout", 32'(lowc), 32'(cur.brk_clks));
                mstate = M_IDLE; mon_busy = 1'b0;
              end
            end
          end
          M_GUARD: begin
            if (i_baud_tick) c++;
            if (!o_tx) guard_ok = 1'b0;
            if (!o_busy) begin
              check("guard_ticks", 32'(c), 32'(OS));
              check("guard_high", 32'(guard_ok), 32'd1);
              mstate = M_IDLE; mon_busy = 1'b0;
            end else if (c > 2 * OS) begin
              check("guard_timeout", 32'(c), 32'(OS));
              mstate = M_IDLE; mon_busy = 1'b0;
            end
          end
          default: mstate = M_IDLE;
        endcase
        prev_tx = o_tx;
      end
    end
  end

  // Queues the expected frame, presents the word and returns on the negedge after acceptance.
  task automatic send(input logic [8:0] d, input int num, input int par, input int stop,
                      input bit hold, input bit b2b, input bit completes, input bit chk_bitclk);
    exp_t e;
    int   n;
    e = mk_frame(d, num, par, stop, DMAX);
    e.b2b = b2b;
    e.chk_bitclk = chk_bitclk;
    sb.push_back(e);
    if (completes) exp_done++;
    i_data = d; i_data_num = 3'(num); i_par = 3'(par); i_stop_num = 2'(stop);
    i_valid = 1'b1;
    n = 0;
    while (!o_ready && n < 5000) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 5000) check("accept_timeout", 32'(o_ready), 32'd1);
    @(posedge i_clk);
    @(negedge i_clk);
    if (!hold) i_valid = 1'b0;
  endtask

  task automatic push_break(input int clks);
    exp_t e;
    e = '{default: 0};
    e.is_break = 1'b1;
    e.brk_clks = clks;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || mon_busy) && n < 6000) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 6000) check("idle_timeout", 32'(sb.size()), 32'd0);
    repeat (4) @(negedge i_clk);
  endtask

  initial begin : stim
    int n, c;
    repeat (3) @(negedge i_clk);
    check("rst_tx", 32'(o_tx), 32'd1);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_tx_done_tick), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd1);
    i_break = 1'b1;
    #1;
    check("rst_ready_break", 32'(o_ready), 32'd0);
    @(negedge i_clk);
    i_break = 1'b0;
    i_reset_n = 1'b1;
    repeat (5) @(negedge i_clk);

    // Frame formats
    send(9'h0A5, 3, 0, 0, 0, 0, 1, 1); wait_idle();
    send(9'h035, 2, 1, 0, 0, 0, 1, 0); wait_idle();
    send(9'h007, 3, 2, 2, 0, 0, 1, 0); wait_idle();
    send(9'h1FF, 4, 3, 1, 0, 0, 1, 0); wait_idle();
    send(9'h01F, 0, 4, 0, 0, 0, 1, 0); wait_idle();
    send(9'h155, 7, 0, 0, 0, 0, 1, 0); wait_idle();

    // Config changes after accept must not affect the frame in flight
    send(9'h0C6, 3, 2, 0, 0, 0, 1, 0);
    repeat (100) @(negedge i_clk);
    i_data = '0; i_data_num = 3'd0; i_par = 3'd0; i_stop_num = 2'd2;
    wait_idle();

    // Back-to-back with valid held
    send(9'h055, 3, 0, 0, 1, 0, 1, 0);
    send(9'h0AA, 3, 0, 0, 0, 1, 1, 0);
    wait_idle();

    // Break in IDLE with a word already pending; the word must follow the guard
    push_break(1000);
    i_break = 1'b1;
    #1;
    check("ready_with_break", 32'(o_ready), 32'd0);
    fork
      send(9'h03C, 3, 0, 0, 0, 0, 1, 0);
      begin
        repeat (500) @(negedge i_clk);
        check("ready_in_break", 32'(o_ready), 32'd0);
        check("busy_in_break", 32'(o_busy), 32'd1);
        repeat (500) @(negedge i_clk);
        i_break = 1'b0;
      end
    join
    wait_idle();

    // Break requested mid-frame starts only after the frame completes
    send(9'h081, 3, 0, 0, 0, 0, 1, 0);
    repeat (200) @(negedge i_clk);
    i_break = 1'b1;
    push_break(100);
    n = 0;
    while (!o_tx_done_tick && n < 2000) begin
      @(negedge i_clk);
      n++;
    end
    check("done_before_break", 32'(o_tx_done_tick), 32'd1);
    repeat (100) @(negedge i_clk);
    i_break = 1'b0;
    wait_idle();

    // Reset during data bit 3 drops the word; the next word goes out normally
    send(9'h05A, 3, 0, 0, 0, 0, 0, 0);
    repeat (287) @(negedge i_clk);
    i_reset_n = 1'b0;
    #1;
    check("midreset_tx", 32'(o_tx), 32'd1);
    check("midreset_busy", 32'(o_busy), 32'd0);
    repeat (3) @(negedge i_clk);
    i_reset_n = 1'b1;
    repeat (3) @(negedge i_clk);
    send(9'h096, 3, 1, 0, 0, 0, 1, 0);
    wait_idle();

    // DBIT_MAX=8 instance clamps a 9-bit request to 8 bits
    i_data = 9'h0C3; i_data_num = 3'd4; i_par = 3'd0; i_stop_num = 2'd0;
    i_valid8 = 1'b1;
    n = 0;
    while (!o_ready8 && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    @(posedge i_clk); #1;
    i_valid8 = 1'b0;
    c = 0; n = 0;
    while (n < 2000) begin
      @(posedge i_clk); #1;
      n++;
      if (i_baud_tick) c++;
      if (o_tx_done_tick8) break;
    end
    check("dut8_frame_ticks", 32'(c), 32'(OS * 10));
    repeat (4) @(negedge i_clk);

    check("done_pulses", 32'(done_cnt), 32'(exp_done));
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised UART transmitter with a valid/ready input handshake, runtime frame format (5–9 data bits; none/even/odd/mark/space parity; 1, 1.5 or 2 stop bits), per-frame configuration latching and line-break generation. It sits between a TX FIFO or host register and the serial pin. It consumes the same oversampled baud tick as the rest of the UART family, so it shares one baud generator with the receiver.

## Interface
- `DBIT_MAX`, 8: widest data word supported, 5..9; sets the `i_data` width.
- `OVERSAMPLE`, 16: baud ticks per bit. Must be even and ≥4.
- `i_clk` in 1: system clock, rising edge.
- `i_reset_n` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `i_baud_tick` in 1: one-cycle enable, OVERSAMPLE per bit period.
- `i_data` in DBIT_MAX: word to send, LSB first.
- `i_valid` in 1: `i_data` and the config inputs are valid.
- `o_ready` out 1: word accepted on an edge where `i_valid & o_ready`.
- `i_data_num` in 3: data bits = 5 + value, clamped to DBIT_MAX.
- `i_par` in 3: parity mode. 000 none, 001 even, 010 odd, 011 mark (1), 100 space (0), others none.
- `i_stop_num` in 2: 00 = 1 stop bit, 01 = 1.5, 10/11 = 2.
- `i_break` in 1: request a line break.
- `o_tx` out 1: serial line, registered.
- `o_busy` out 1: high in any state other than IDLE.
- `o_tx_done_tick` out 1: one-cycle pulse per completed frame, registered.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, BREAK, GUARD.
- `o_ready` = (state == IDLE) & ~`i_break`. This is combinational.
- **IDLE:** `o_tx` = 1.
  - On accept: latch `i_data`, the clamped bit count, parity mode and stop length; clear the tick counter, bit counter and parity accumulator; go to START.
  - If `i_break` = 1: go to BREAK. Break has priority over `i_valid`, so no accept occurs.
- **Frame config:** the latched config alone governs the frame. Input changes after accept have no effect until the next accept.
- **START:** `o_tx` = 0 for OVERSAMPLE ticks, then go to DATA.
- **DATA:** `o_tx` = shift register bit 0, for OVERSAMPLE ticks per bit.
  - At each bit end: XOR the bit into the accumulator, shift right, increment the bit count.
  - After the last bit: go to PARITY if the mode is not none, else go to STOP.
- **PARITY:** `o_tx` is set by mode, then go to STOP after OVERSAMPLE ticks.
  - even: accumulator.
  - odd: ~accumulator.
  - mark: 1.
  - space: 0.
- **STOP:** `o_tx` = 1 for OVERSAMPLE, 3·OVERSAMPLE/2 or 2·OVERSAMPLE ticks. Then go to IDLE and pulse `o_tx_done_tick`.
- **BREAK:** `o_tx` = 0 while `i_break` = 1. Break length has no minimum and is independent of ticks. On deassert, go to GUARD.
- **GUARD:** `o_tx` = 1 for OVERSAMPLE ticks, then go to IDLE. No done pulse.
- `i_break` is ignored outside IDLE and BREAK. A break request made mid-frame takes effect only after the frame ends.
- Tick counter width is clog2(2·OVERSAMPLE). It wraps to 0 at every bit boundary.
- The bit counter is sized to count up to DBIT_MAX.

## Timing
- Reset values: `o_tx` = 1, `o_busy` = 0, `o_tx_done_tick` = 0, state IDLE. `o_ready` = ~`i_break`.
- **Reset mid-frame:** `o_tx` returns to 1 asynchronously and the word is lost. No done pulse.
- **Start edge:** `o_tx` falls on the accept edge. `o_tx` is loaded from the next-state value, so there is no extra cycle of lag.
- **Bit boundaries:** each bit ends on the edge that samples its OVERSAMPLE-th `i_baud_tick`. `o_tx` changes on that same edge.
- Ticks arriving on the accept edge are not counted.
- **Done pulse:** `o_tx_done_tick` is high in the cycle after the final stop tick. `o_ready` is 1 in that same cycle.
- **Back-to-back frames:** with `i_valid` held high, the next word is accepted in that cycle. The stop bit is therefore extended by exactly one clock.
- **Frame length** in ticks = OVERSAMPLE·(1 + N + P) + stop ticks, where P ∈ {0,1}.

## Test plan
- **8N1:** DBIT_MAX=9, OVERSAMPLE=16, tick every 4 clocks; send 0xA5 (`i_data_num`=3, `i_par`=0, `i_stop_num`=0).
  - Line: 0, 1,0,1,0,0,1,0,1, 1.
  - Each bit lasts 64 clocks; frame = 160 ticks.
  - Exactly one `o_tx_done_tick`.
- **Parity modes:**
  - 7E1 0x35 → parity 0.
  - 8O2 0x07 → parity 0, stop lasts 32 ticks.
  - 9-bit mark 0x1FF with 1.5 stop → parity 1, stop lasts 24 ticks.
  - 5-bit space 0x1F → parity 0.
- **Latching and clamping:**
  - Change `i_data_num` 3→0 and `i_par` during a frame → frame still has 8 bits and the original parity.
  - DBIT_MAX=8 with `i_data_num`=4 → 8 bits sent.
- **Back-to-back:** `i_valid` held high with 0x55 then 0xAA → second start edge comes one clock after the done pulse; two done pulses total.
- **Break:**
  - Assert `i_break` for 1000 clocks in IDLE → `o_tx` low for 1000 clocks, `o_ready` = 0, then high for 16 ticks before `o_ready` returns; no done pulse.
  - `i_break` asserted mid-frame → frame completes intact, then break starts.
- **Reset mid-frame:** drop `i_reset_n` during DATA bit 3 → `o_tx` = 1 and `o_busy` = 0 immediately; the next accepted frame is transmitted normally.
